io_dma_master: RTL and testbench
================================

IO_DMA_MASTER -- requirements
Module: io_dma_master

Interface
REQ-001 SHALL have parameter: ADDR_W, 24, bus address width.
REQ-002 SHALL have port: clk_mem  input  1  the single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a transfer using cfg_* values.
REQ-005 SHALL have port: abort  input  1  stop the transfer at the next beat boundary.
REQ-006 SHALL have ports: cfg_src, cfg_dst  input  ADDR_W  source and destination byte addresses.
REQ-007 SHALL have port: cfg_count  input  14  beat count; 0 means 16384 beats.
REQ-008 SHALL have port: cfg_word  input  1  1 = 32-bit beats, 0 = 16-bit beats.
REQ-009 SHALL have ports: cfg_src_ctl, cfg_dst_ctl  input  2  00 increment, 01 decrement, 10 fixed, 11 treated as 10.
REQ-010 SHALL have port: addr  output  ADDR_W  bus address.
REQ-011 SHALL have port: wdata  output  32  write data to the responder.
REQ-012 SHALL have port: rdata  input  32  read data from the responder, valid when ready=1.
REQ-013 SHALL have ports: read, write  output  1  bus strobes, never both high.
REQ-014 SHALL have port: width  output  2  01 halfword, 10 word.
REQ-015 SHALL have port: ready  input  1  responder completes the current beat on a rising edge with ready=1.
REQ-016 SHALL have ports: busy, done  output  1  transfer active; one-cycle completion pulse.
REQ-017 SHALL have port: irq  output  1  level interrupt, cleared by the next start.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, FIN.
- IDLE->RD on start.
- RD->WR on ready.
- WR->RD on ready with beats remaining and no pending abort.
- WR->FIN on ready when it is the last beat or an abort is pending.
- FIN->IDLE after exactly one cycle.
REQ-019 SHALL latch cfg_* on start in IDLE and SHALL ignore start in any other state.
REQ-020 SHALL force latched addresses aligned: bit 0 cleared for halfword, bits 1:0 cleared for word.
REQ-021 SHALL in RD drive read=1, addr=src pointer, and capture rdata into the data register on ready.
REQ-022 SHALL in WR drive write=1, addr=dst pointer, wdata=data register, halfword data in bits 15:0 and upper bits zero.
REQ-023 SHALL hold addr, width and strobes stable while ready=0, with no timeout.
REQ-024 SHALL step each pointer by 2 (halfword) or 4 (word) after its beat completes, per its ctl field.
REQ-025 SHALL wrap pointer arithmetic modulo 2^ADDR_W.
REQ-026 SHALL hold the remaining-beat counter at 15 bits, load 16384 for cfg_count=0, and decrement once per completed WR beat.
REQ-027 SHALL latch abort asserted in any non-IDLE state as pending; a beat already started in RD SHALL still complete its WR.
REQ-028 SHALL assert busy in RD and WR only, and done only in FIN.
REQ-029 SHALL have a latency of 2 cycles per beat with ready tied to 1; start to done is 2N+1 cycles for N beats.

Reset
REQ-030 SHALL on rst_n low, immediately and regardless of state: enter IDLE; drive read=0, write=0, busy=0, done=0, irq=0, addr=0, wdata=0, width=01; clear the counter and the pending abort.
REQ-031 SHALL after reset mid-transfer resume only on a new start.

Configuration
REQ-032 SHALL with macro DMA_IRQ_EN defined set irq in FIN and clear it on an accepted start.
REQ-033 SHALL without DMA_IRQ_EN tie irq to 0 and leave done unchanged.

Verification
REQ-034 SHALL cover: src=0x000100 inc, dst=0x000200 inc, count=3, word, ready=1 -> reads 0x100/0x104/0x108, writes 0x200/0x204/0x208, done at cycle 7.
REQ-035 SHALL cover: halfword, src=0x000103 fixed, dst=0x000300 decrement, count=2 -> reads 0x102 twice; writes 0x300 then 0x2FE with data[31:16]=0.
REQ-036 SHALL cover: ready low 3 cycles during the first RD -> addr and read held, with rdata captured only on the ready cycle.
REQ-037 SHALL cover: abort pulsed during RD of beat 2 of 5 -> beat 2 write completes, done follows, no third read.
REQ-038 SHALL cover: dst=0xFFFFFC inc, word, count=2 -> second write at 0x000000; count=0 -> 16384 writes before done.
REQ-039 SHALL cover: rst_n low mid-WR -> outputs at reset values immediately; start ignored while busy; irq set at FIN only with DMA_IRQ_EN.

Source files
------------

// File: rtl/io_dma_master.sv
// ---------------------------------------------------------------------------
// io_dma_master
//
// Single-channel memory-to-memory DMA bus master. On start (in IDLE) the
// cfg_* values are latched and the engine runs N beats, each beat being one
// read from the source pointer followed by one write to the destination
// pointer. With ready tied high each beat takes two cycles; start to done
// is 2N+1 cycles.
//
// Optional feature: define DMA_IRQ_EN to get a level interrupt that sets
// in FIN and clears on the next accepted start. Without it irq is tied 0.
//
// Ports
//   clk_mem      in   single clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle request to begin a transfer (IDLE only)
//   abort        in   stop at the next beat boundary
//   cfg_src      in   source byte address          [ADDR_W]
//   cfg_dst      in   destination byte address     [ADDR_W]
//   cfg_count    in   beat count, 0 means 16384    [14]
//   cfg_word     in   1 = 32-bit beats, 0 = 16-bit beats
//   cfg_src_ctl  in   00 inc, 01 dec, 10/11 fixed  [2]
//   cfg_dst_ctl  in   00 inc, 01 dec, 10/11 fixed  [2]
//   addr         out  bus address                  [ADDR_W]
//   wdata        out  write data                   [32]
//   rdata        in   read data, valid with ready  [32]
//   read, write  out  bus strobes (mutually exclusive)
//   width        out  01 halfword, 10 word         [2]
//   ready        in   responder completes the current beat
//   busy         out  high in RD and WR
//   done         out  one-cycle pulse in FIN
//   irq          out  level interrupt (DMA_IRQ_EN only)
// ---------------------------------------------------------------------------
module io_dma_master #(
  parameter int ADDR_W = 24
) (
  input  logic              clk_mem,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [13:0]       cfg_count,
  input  logic              cfg_word,
  input  logic [1:0]        cfg_src_ctl,
  input  logic [1:0]        cfg_dst_ctl,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic              read,
  output logic              write,
  output logic [1:0]        width,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [1:0]        src_ctl;
  logic [1:0]        dst_ctl;
  logic              word_mode;
  logic [14:0]       beats_left;
  logic              abort_pend;
  logic [31:0]       data_reg;

  logic [ADDR_W-1:0] src_ptr_next;
  logic [ADDR_W-1:0] dst_ptr_next;
  logic [ADDR_W-1:0] src_aligned;
  logic [ADDR_W-1:0] dst_aligned;
  logic              last_beat;
  logic              stop_after_wr;

  // Force the low address bits to zero for the selected beat size.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                   input logic              wd);
    logic [ADDR_W-1:0] r;
    r = a;
    r[0] = 1'b0;
    if (wd) r[1] = 1'b0;
    return r;
  endfunction

  // Advance a pointer by one beat; 10 and 11 both mean fixed. Arithmetic
  // wraps naturally at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] p,
                                                  input logic [1:0]        ctl,
                                                  input logic              wd);
    logic [ADDR_W-1:0] inc;
    inc = wd ? ADDR_W'(4) : ADDR_W'(2);
    case (ctl)
      2'b00:   return p + inc;
      2'b01:   return p - inc;
      default: return p;
    endcase
  endfunction

  always_comb begin
    src_ptr_next  = step_addr(src_ptr, src_ctl, word_mode);
    dst_ptr_next  = step_addr(dst_ptr, dst_ctl, word_mode);
    src_aligned   = align_addr(cfg_src, cfg_word);
    dst_aligned   = align_addr(cfg_dst, cfg_word);
    last_beat     = (beats_left == 15'd1);
    // An abort arriving on the very edge a write completes also ends the
    // transfer there, since that edge is itself a beat boundary.
    stop_after_wr = last_beat || abort_pend || abort;
  end

  assign wdata = data_reg;

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      src_ctl    <= 2'b00;
      dst_ctl    <= 2'b00;
      word_mode  <= 1'b0;
      beats_left <= '0;
      abort_pend <= 1'b0;
      data_reg   <= '0;
      addr       <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      width      <= 2'b01;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DMA_IRQ_EN
      irq        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_ptr    <= src_aligned;
            dst_ptr    <= dst_aligned;
            src_ctl    <= cfg_src_ctl;
            dst_ctl    <= cfg_dst_ctl;
            word_mode  <= cfg_word;
            beats_left <= (cfg_count == 14'd0) ? 15'd16384 : {1'b0, cfg_count};
            abort_pend <= 1'b0;
            addr       <= src_aligned;
            width      <= cfg_word ? 2'b10 : 2'b01;
            read       <= 1'b1;
            busy       <= 1'b1;
            state      <= RD;
`ifdef DMA_IRQ_EN
            irq        <= 1'b0;
`endif
          end
        end

        RD: begin
          if (abort) abort_pend <= 1'b1;
          if (ready) begin
            // Halfword beats carry only the low lane; upper bits forced zero.
            data_reg <= word_mode ? rdata : {16'h0000, rdata[15:0]};
            src_ptr  <= src_ptr_next;
            addr     <= dst_ptr;
            read     <= 1'b0;
            write    <= 1'b1;
            state    <= WR;
          end
        end

        WR: begin
          if (ready) begin
            dst_ptr    <= dst_ptr_next;
            beats_left <= beats_left - 15'd1;
            write      <= 1'b0;
            if (stop_after_wr) begin
              abort_pend <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= FIN;
`ifdef DMA_IRQ_EN
              irq        <= 1'b1;
`endif
            end else begin
              // src_ptr was already stepped when the read completed.
              addr  <= src_ptr;
              read  <= 1'b1;
              state <= RD;
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef DMA_IRQ_EN
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_dma_master.sv
module tb_io_dma_master;

  logic        clk_mem;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [23:0] cfg_src;
  logic [23:0] cfg_dst;
  logic [13:0] cfg_count;
  logic        cfg_word;
  logic [1:0]  cfg_src_ctl;
  logic [1:0]  cfg_dst_ctl;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        read;
  logic        write;
  logic [1:0]  width;
  logic        ready;
  logic        busy;
  logic        done;
  logic        irq;

  int checks = 0;
  int failures = 0;

`ifdef DMA_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  io_dma_master #(.ADDR_W(24)) dut (
    .clk_mem     (clk_mem),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_src     (cfg_src),
    .cfg_dst     (cfg_dst),
    .cfg_count   (cfg_count),
    .cfg_word    (cfg_word),
    .cfg_src_ctl (cfg_src_ctl),
    .cfg_dst_ctl (cfg_dst_ctl),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .read        (read),
    .write       (write),
    .width       (width),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .irq         (irq)
  );

  initial begin
    clk_mem = 1'b0;
    forever #5 clk_mem = ~clk_mem;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Address of beat i computed directly from the base, the direction and
  // the beat index; 24-bit truncation gives the modulo wrap.
  function automatic logic [23:0] beat_addr(input logic [23:0] base, input logic [1:0] ctl,
                                            input logic word, input int i);
    logic [23:0] a;
    int          stp;
    a = base;
    a[0] = 1'b0;
    if (word) a[1] = 1'b0;
    stp = word ? 4 : 2;
    if (ctl == 2'b00) return a + 24'(stp * i);
    if (ctl == 2'b01) return a - 24'(stp * i);
    return a;
  endfunction

  // stall: 0 ready always 1, 1 random ready, 2 ready low 3 cycles in first RD.
  // abort_beat: 0 none, k = pulse abort during the read of beat k.
  // poke: try a second start with altered cfg in the middle of the transfer.
  task automatic run_xfer(input logic [23:0] src, input logic [23:0] dst,
                          input logic [13:0] cnt, input logic word,
                          input logic [1:0] sctl, input logic [1:0] dctl,
                          input int stall, input int abort_beat, input bit poke,
                          output logic [23:0] first_rd, output logic [23:0] last_wr,
                          output int nbeats);
    int          n;
    int          exp_n;
    int          rd_i;
    int          wr_i;
    int          cyc;
    int          stall_left;
    int          budget;
    bit          fin;
    logic        rdy;
    logic [31:0] cur_rdata;
    logic [31:0] exp_data;
    n          = (cnt == 14'd0) ? 16384 : int'(cnt);
    exp_n      = (abort_beat > 0 && abort_beat < n) ? abort_beat : n;
    rd_i       = 0;
    wr_i       = 0;
    cyc        = 0;
    stall_left = 3;
    budget     = 8 * n + 60;
    fin        = 1'b0;
    exp_data   = '0;
    first_rd   = '0;
    last_wr    = '0;
    cfg_src     = src;
    cfg_dst     = dst;
    cfg_count   = cnt;
    cfg_word    = word;
    cfg_src_ctl = sctl;
    cfg_dst_ctl = dctl;
    start       = 1'b1;
    ready       = 1'b1;
    abort       = 1'b0;
    @(negedge clk_mem);
    start = 1'b0;
    while (!fin) begin
      cyc++;
      if (cyc > budget) begin
        chk("timeout_waiting_done", 32'(cyc), 32'(budget));
        break;
      end
      rdy = 1'b1;
      if (stall == 1) rdy = ($urandom_range(3) != 0);
      if (stall == 2 && read && rd_i == 0 && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      cur_rdata = $urandom;
      ready     = rdy;
      rdata     = cur_rdata;
      abort     = (abort_beat > 0 && read && rd_i == abort_beat - 1);
      start     = poke && (cyc == 3);
      if (poke && cyc == 3) begin
        cfg_src   = src ^ 24'h00F0F0;
        cfg_dst   = dst ^ 24'h0F0F00;
        cfg_count = 14'd1;
      end
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1'b1);
        chk("irq_cleared_by_start", irq, 1'b0);
      end
      chk("strobes_exclusive", read & write, 1'b0);
      chk("busy_vs_strobes", busy, read | write);
      if (read) begin
        chk("rd_addr", addr, beat_addr(src, sctl, word, rd_i));
        chk("rd_width", width, word ? 2'b10 : 2'b01);
        if (rd_i == 0) first_rd = addr;
        if (rdy) begin
          exp_data = word ? cur_rdata : {16'h0000, cur_rdata[15:0]};
          rd_i++;
        end
      end
      if (write) begin
        chk("wr_addr", addr, beat_addr(dst, dctl, word, wr_i));
        chk("wr_data", wdata, exp_data);
        if (rdy) begin
          last_wr = addr;
          wr_i++;
        end
      end
      if (done) begin
        chk("reads_at_done", 32'(rd_i), 32'(exp_n));
        chk("writes_at_done", 32'(wr_i), 32'(exp_n));
        if (stall == 0) chk("done_cycle", 32'(cyc), 32'(2 * exp_n + 1));
        chk("irq_at_fin", irq, IRQ_EXP);
        fin = 1'b1;
      end
      @(negedge clk_mem);
    end
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b1;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
    chk("irq_after_fin", irq, IRQ_EXP);
    nbeats = wr_i;
  endtask

  typedef struct {
    logic [23:0] src;
    logic [23:0] dst;
    logic [13:0] cnt;
    logic        word;
    logic [1:0]  sctl;
    logic [1:0]  dctl;
    int          stall;
    int          abort_beat;
    logic [23:0] exp_first_rd;
    logic [23:0] exp_last_wr;
    int          exp_beats;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [23:0] f_rd;
    logic [23:0] l_wr;
    int          nb;
    int          w;

    vt[0] = '{24'h000100, 24'h000200, 14'd3, 1'b1, 2'b00, 2'b00, 0, 0, 24'h000100, 24'h000208, 3};
    vt[1] = '{24'h000103, 24'h000300, 14'd2, 1'b0, 2'b10, 2'b01, 0, 0, 24'h000102, 24'h0002FE, 2};
    vt[2] = '{24'h000010, 24'hFFFFFC, 14'd2, 1'b1, 2'b00, 2'b00, 0, 0, 24'h000010, 24'h000000, 2};
    vt[3] = '{24'h000100, 24'h000500, 14'd5, 1'b1, 2'b00, 2'b00, 0, 2, 24'h000100, 24'h000504, 2};
    vt[4] = '{24'h000002, 24'h000400, 14'd2, 1'b1, 2'b01, 2'b11, 2, 0, 24'h000000, 24'h000400, 2};
    vt[5] = '{24'hFFFFFF, 24'h000001, 14'd3, 1'b0, 2'b00, 2'b01, 1, 0, 24'hFFFFFE, 24'hFFFFFC, 3};

    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    ready       = 1'b1;
    rdata       = '0;
    cfg_src     = '0;
    cfg_dst     = '0;
    cfg_count   = '0;
    cfg_word    = 1'b0;
    cfg_src_ctl = 2'b00;
    cfg_dst_ctl = 2'b00;
    repeat (2) @(negedge clk_mem);
    chk("rst_read", read, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_addr", addr, 24'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_width", width, 2'b01);
    rst_n = 1'b1;
    @(negedge clk_mem);

    // Table of directed transfers.
    for (int i = 0; i < 6; i++) begin
      run_xfer(vt[i].src, vt[i].dst, vt[i].cnt, vt[i].word, vt[i].sctl, vt[i].dctl,
               vt[i].stall, vt[i].abort_beat, 1'b0, f_rd, l_wr, nb);
      chk($sformatf("vec%0d_first_rd", i), f_rd, vt[i].exp_first_rd);
      chk($sformatf("vec%0d_last_wr", i), l_wr, vt[i].exp_last_wr);
      chk($sformatf("vec%0d_beats", i), 32'(nb), 32'(vt[i].exp_beats));
      @(negedge clk_mem);
    end

    // Second start while busy must be ignored.
    run_xfer(24'h000800, 24'h000900, 14'd4, 1'b1, 2'b00, 2'b00, 0, 0, 1'b1, f_rd, l_wr, nb);
    chk("poke_beats", 32'(nb), 32'd4);
    chk("poke_last_wr", l_wr, 24'h00090C);
    @(negedge clk_mem);

    // Reset in the middle of a write.
    cfg_src     = 24'h000040;
    cfg_dst     = 24'h000080;
    cfg_count   = 14'd4;
    cfg_word    = 1'b1;
    cfg_src_ctl = 2'b00;
    cfg_dst_ctl = 2'b00;
    ready       = 1'b1;
    start       = 1'b1;
    @(negedge clk_mem);
    start = 1'b0;
    w = 0;
    while (!write && w < 10) begin
      @(negedge clk_mem);
      w++;
    end
    chk("reach_wr_before_reset", write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_read", read, 1'b0);
    chk("midrst_write", write, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_irq", irq, 1'b0);
    chk("midrst_addr", addr, 24'h0);
    chk("midrst_wdata", wdata, 32'h0);
    chk("midrst_width", width, 2'b01);
    @(negedge clk_mem);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_mem);
      chk("stay_idle_busy", busy, 1'b0);
      chk("stay_idle_read", read, 1'b0);
    end
    run_xfer(24'h000040, 24'h000080, 14'd2, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, f_rd, l_wr, nb);
    chk("post_reset_beats", 32'(nb), 32'd2);
    @(negedge clk_mem);

    // Randomized transfers against the reference model.
    for (int r = 0; r < 8; r++) begin
      logic [13:0] rc;
      rc = 14'($urandom_range(1, 8));
      run_xfer(24'($urandom), 24'($urandom), rc, 1'($urandom), 2'($urandom), 2'($urandom),
               int'($urandom_range(0, 1)), 0, 1'b0, f_rd, l_wr, nb);
      chk("rand_beats", 32'(nb), 32'(rc));
      @(negedge clk_mem);
    end

    // count=0 means 16384 beats.
    run_xfer(24'h001000, 24'h100000, 14'd0, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0, f_rd, l_wr, nb);
    chk("count0_beats", 32'(nb), 32'd16384);
    chk("count0_last_wr", l_wr, 24'h10FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
